// File: rtl/au_extrema_seq.sv
// au_extrema_seq: streaming frame-extrema front-end.
// Folds signed samples into running max, min and saturated peak-magnitude
// registers. It presents one result per frame on a valid/ready output port.
module au_extrema_seq #(
  parameter int msb       = 15,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [msb:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [msb:0]     out_max,
  output logic [msb:0]     out_min,
  output logic [msb:0]     out_abs,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic [msb:0]       r_max;
  logic [msb:0]       r_min;
  logic [msb:0]       r_abs;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;

  logic [msb:0]       w_most_neg;
  logic [msb:0]       w_abs_x;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_accept;
  logic               w_close;

  assign w_most_neg = {1'b1, {msb{1'b0}}};

  // in_ready depends only on state (and reset), never on in_valid.
  assign in_ready = !rst && (r_state != ST_DONE);
  assign w_accept = in_valid && in_ready;

  // Count the accepted sample would produce; the first sample of a frame restarts at 1.
  assign w_cnt_next = (r_state == ST_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_close    = in_last || (w_cnt_next == CNT_W'(FRAME_LEN));

  // Saturating magnitude of the incoming sample; the most negative value maps to max positive.
  always_comb begin
    // NOTE: a default assignment first means every path drives w_abs_x, so no latch is inferred.
    w_abs_x = in_data;
    if (in_data[msb]) begin
      if (in_data == w_most_neg) begin
        w_abs_x = ~w_most_neg;
      end else begin
        w_abs_x = -in_data;
      end
    end
  end

  // Frame FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_max       <= '0;
      r_min       <= '0;
      r_abs       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, as flops do.
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_max <= in_data;
            r_min <= in_data;
            r_abs <= w_abs_x;
            r_cnt <= w_cnt_next;
            if (w_close) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (w_accept) begin
            if ($signed(in_data) > $signed(r_max)) r_max <= in_data;
            if ($signed(in_data) < $signed(r_min)) r_min <= in_data;
            if (w_abs_x > r_abs) r_abs <= w_abs_x;
            r_cnt <= w_cnt_next;
            if (w_close) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_max   = r_max;
  assign out_min   = r_min;
  assign out_abs   = r_abs;
  assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_au_extrema_seq.sv
// tb_au_extrema_seq: directed plus randomized frames checked against a
// queue-based reference model of frame extrema.
module tb_au_extrema_seq;

  localparam int FRAME_LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_max;
  logic [15:0] out_min;
  logic [15:0] out_abs;
  logic [7:0]  out_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];

  au_extrema_seq #(.msb(15), .FRAME_LEN(FRAME_LEN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min), .out_abs(out_abs), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: frame extrema from the list of accepted samples.
  function automatic logic [15:0] model_max();
    int m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return 16'(m);
  endfunction

  function automatic logic [15:0] model_min();
    int m = q[0];
    foreach (q[i]) if (q[i] < m) m = q[i];
    return 16'(m);
  endfunction

  function automatic logic [15:0] model_abs();
    int m = 0;
    foreach (q[i]) begin
      int a = (q[i] < 0) ? -q[i] : q[i];
      if (a > 32767) a = 32767;
      if (a > m) m = a;
    end
    return 16'(m);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".max"}, 32'(out_max), 32'(model_max()));
    check({tag, ".min"}, 32'(out_min), 32'(model_min()));
    check({tag, ".abs"}, 32'(out_abs), 32'(model_abs()));
    check({tag, ".cnt"}, 32'(out_cnt), 32'(q.size()));
  endtask

  // Offer one sample, wait (bounded) for acceptance, record it, check out_valid after the edge.
  task automatic push(input logic [15:0] x, input bit last);
    int  n = 0;
    bit  exp_close;
    @(negedge clk);
    in_valid = 1'b1; in_data = x; in_last = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
      q.push_back(int'($signed(x)));
      exp_close = last || (q.size() == FRAME_LEN);
      check("out_valid_after_push", 32'(out_valid), 32'(exp_close));
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Hold the result for 'delay' cycles, check it, then complete the output handshake.
  task automatic pop(input string tag, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check_outputs(tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(in_ready), 32'd1);
    q.delete();
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.outs", {out_max, out_min}, 32'd0);
    check("rst.abs_cnt", {8'd0, out_abs, out_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel.in_ready", 32'(in_ready), 32'd1);

    // Mixed-sign frame.
    push(16'd5, 0); push(-16'sd3, 0); push(16'd12, 0); push(-16'sd7, 1);
    check("f1.max_lit", 32'(out_max), 32'h000C);
    check("f1.min_lit", 32'(out_min), 32'hFFF9);
    pop("f1", 0);

    // Most-negative sample saturates the magnitude.
    push(16'h8000, 0); push(16'h0001, 1);
    check("f2.abs_sat", 32'(out_abs), 32'h7FFF);
    pop("f2", 0);

    // FRAME_LEN close, then a held 9th sample stalls while out_ready is low.
    for (int i = 1; i <= 8; i++) push(16'(i), 0);
    check_outputs("f3");
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd9; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("f3.stall_ready", 32'(in_ready), 32'd0);
      check("f3.stall_valid", 32'(out_valid), 32'd1);
      check("f3.stall_max", 32'(out_max), 32'd8);
      check("f3.stall_cnt", 32'(out_cnt), 32'd8);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("f3.pop_valid", 32'(out_valid), 32'd0);
    check("f3.pop_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    q.delete();
    q.push_back(9);
    check("f4.valid", 32'(out_valid), 32'd1);
    pop("f4", 0);

    // Single-sample frame.
    push(-16'sd20, 1);
    check("f5.max_lit", 32'(out_max), 32'hFFEC);
    check("f5.abs_lit", 32'(out_abs), 32'd20);
    pop("f5", 2);

    // Asynchronous reset mid-frame discards the partial frame.
    push(16'd100, 0); push(-16'sd50, 0); push(16'd33, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd0);
    check("arst.outs", {out_max, out_min}, 32'd0);
    check("arst.abs_cnt", {8'd0, out_abs, out_cnt}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    push(16'd4, 1);
    check("f6.cnt", 32'(out_cnt), 32'd1);
    pop("f6", 0);

    // Randomized frames with random lengths, extremes and result back-pressure.
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(1, FRAME_LEN);
      bit last_on_end = (len < FRAME_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int s = 0; s < len; s++) begin
        logic [15:0] x;
        case ($urandom_range(0, 7))
          0:       x = 16'h8000;
          1:       x = 16'h7FFF;
          2:       x = 16'h0000;
          default: x = 16'($urandom);
        endcase
        push(x, (s == len - 1) ? last_on_end : 1'b0);
      end
      pop("rnd", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
